// File: rtl/traffic_pkg.sv
// traffic_pkg: controller states, lamp encodings and per-road lamp decode.
package traffic_pkg;
   typedef enum logic [2:0] {
      NS_GREEN, NS_YELLOW, ALL_RED, EW_GREEN, EW_YELLOW, PED_WALK, FLASH_ON, FLASH_OFF
   } state_t;
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;
   function automatic logic [2:0] ns_lamp(state_t s);
      return s == NS_GREEN  ? LAMP_GRN :
             s == NS_YELLOW ? LAMP_YEL :
             s == FLASH_ON  ? LAMP_YEL :
             s == FLASH_OFF ? LAMP_OFF : LAMP_RED;
   endfunction
   function automatic logic [2:0] ew_lamp(state_t s);
      return s == EW_GREEN  ? LAMP_GRN :
             s == EW_YELLOW ? LAMP_YEL :
             s == FLASH_ON  ? LAMP_YEL :
             s == FLASH_OFF ? LAMP_OFF : LAMP_RED;
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: down counter reloaded by the owner; done while it reads zero.
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk) r_cnt <= load ? load_val : r_cnt - 1'b1;
   assign done = r_cnt == '0;
endmodule

// File: rtl/traffic_controller_param.sv
// traffic_controller_param: two-road signal controller with pedestrian walk
// phase and flashing-yellow maintenance mode; all outputs registered.
module traffic_controller_param
   import traffic_pkg::*;
#(
   parameter int GREEN_CYCLES  = 8,
   parameter int YELLOW_CYCLES = 3,
   parameter int ALLRED_CYCLES = 2,
   parameter int PED_CYCLES    = 6,
   parameter int FLASH_HALF    = 4,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req,
   input  logic       flash_mode,
   output logic [2:0] NS,
   output logic [2:0] EW,
   output logic       walk,
   output logic       ped_pending
);
   localparam longint MAXD = longint'(1) << CNT_W;
   if (GREEN_CYCLES < 1 || longint'(GREEN_CYCLES) > MAXD ||
       YELLOW_CYCLES < 1 || longint'(YELLOW_CYCLES) > MAXD ||
       ALLRED_CYCLES < 1 || longint'(ALLRED_CYCLES) > MAXD ||
       PED_CYCLES < 1 || longint'(PED_CYCLES) > MAXD ||
       FLASH_HALF < 1 || longint'(FLASH_HALF) > MAXD) begin : g_bad_duration
      $error("traffic_controller_param: every duration must be in 1..2**CNT_W");
   end
   localparam logic [CNT_W-1:0] L_GRN = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_YEL = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_RED = CNT_W'(ALLRED_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_PED = CNT_W'(PED_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_FLS = CNT_W'(FLASH_HALF - 1);
   state_t           r_state, w_nxt;
   logic             r_next_dir, r_ped, r_walk;
   logic [2:0]       r_ns, r_ew;
   logic             w_done;
   logic [CNT_W-1:0] w_ld_val;
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         NS_GREEN:  w_nxt = NS_YELLOW;
         NS_YELLOW: w_nxt = ALL_RED;
         EW_GREEN:  w_nxt = EW_YELLOW;
         EW_YELLOW: w_nxt = ALL_RED;
         ALL_RED:   w_nxt = flash_mode ? FLASH_ON : r_ped ? PED_WALK : r_next_dir ? EW_GREEN : NS_GREEN;
         PED_WALK:  w_nxt = ALL_RED;
         FLASH_ON:  w_nxt = FLASH_OFF;
         FLASH_OFF: w_nxt = flash_mode ? FLASH_ON : ALL_RED;
      endcase
      if (!w_done) w_nxt = r_state;
   end
   // Reset reloads the timer directly so the first green lasts its full duration.
   assign w_ld_val = reset || w_nxt == NS_GREEN || w_nxt == EW_GREEN ? L_GRN :
                     w_nxt == NS_YELLOW || w_nxt == EW_YELLOW ? L_YEL :
                     w_nxt == ALL_RED ? L_RED :
                     w_nxt == PED_WALK ? L_PED : L_FLS;
   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .load     (reset | w_done),
      .load_val (w_ld_val),
      .done     (w_done)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= NS_GREEN;
         r_next_dir <= 1'b1;
         r_ped      <= 1'b0;
         r_ns       <= LAMP_GRN;
         r_ew       <= LAMP_RED;
         r_walk     <= 1'b0;
      end else begin
         r_state    <= w_nxt;
         r_ns       <= ns_lamp(w_nxt);
         r_ew       <= ew_lamp(w_nxt);
         r_walk     <= w_nxt == PED_WALK;
         r_next_dir <= r_state == NS_YELLOW ? 1'b1 :
                       r_state == EW_YELLOW ? 1'b0 :
                       r_state == FLASH_OFF && w_nxt == ALL_RED ? 1'b0 : r_next_dir;
         r_ped      <= r_state != PED_WALK && w_nxt == PED_WALK ? 1'b0 :
                       ped_req && r_state != PED_WALK ? 1'b1 : r_ped;
      end
   end
   assign NS          = r_ns;
   assign EW          = r_ew;
   assign walk        = r_walk;
   assign ped_pending = r_ped;
endmodule

// File: tb/tb_traffic_controller_param.sv
// tb_traffic_controller_param: directed per-scenario vectors, sampled on negedge.
module tb_traffic_controller_param;
   localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100, O = 3'b000;
   // One row: hold for n cycles expecting lamps/walk/pending, driving preq/fl after each sample.
   typedef struct packed {
      logic [7:0] n;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       w;
      logic       p;
      logic       preq;
      logic       fl;
   } vec_t;
   logic       clk = 1'b0, reset = 1'b1, ped_req = 1'b0, flash_mode = 1'b0;
   logic [2:0] NS, EW;
   logic       walk, ped_pending;
   int         checks = 0, passes = 0;
   traffic_controller_param dut (
      .clk         (clk),
      .reset       (reset),
      .ped_req     (ped_req),
      .flash_mode  (flash_mode),
      .NS          (NS),
      .EW          (EW),
      .walk        (walk),
      .ped_pending (ped_pending)
   );
   always #5 clk = ~clk;
   task automatic test_reset;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks += 4;
      if (NS !== G) $display("FAIL reset_ns: got %b expected %b", NS, G); else passes++;
      if (EW !== R) $display("FAIL reset_ew: got %b expected %b", EW, R); else passes++;
      if (walk !== 1'b0) $display("FAIL reset_walk: got %b expected 0", walk); else passes++;
      if (ped_pending !== 1'b0) $display("FAIL reset_ped: got %b expected 0", ped_pending); else passes++;
      reset = 1'b0;
   endtask
   task automatic test_default_sequence;
      vec_t t [12] = '{
         '{8, G, R, 0, 0, 0, 0}, '{3, Y, R, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0},
         '{8, R, G, 0, 0, 0, 0}, '{3, R, Y, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0},
         '{8, G, R, 0, 0, 0, 0}, '{3, Y, R, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0},
         '{8, R, G, 0, 0, 0, 0}, '{3, R, Y, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0}};
      for (int i = 0; i < 12; i++)
         for (int k = 0; k < int'(t[i].n); k++) begin
            checks++;
            if ({NS, EW, walk, ped_pending} !== {t[i].ns, t[i].ew, t[i].w, t[i].p})
               $display("FAIL default row %0d cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                        i, k, NS, EW, walk, ped_pending, t[i].ns, t[i].ew, t[i].w, t[i].p);
            else passes++;
            ped_req = t[i].preq;
            flash_mode = t[i].fl;
            @(negedge clk);
         end
   endtask
   task automatic test_ped_request;
      vec_t t [10] = '{
         '{1, G, R, 0, 0, 0, 0}, '{1, G, R, 0, 0, 1, 0}, '{6, G, R, 0, 1, 0, 0},
         '{3, Y, R, 0, 1, 0, 0}, '{2, R, R, 0, 1, 0, 0}, '{6, R, R, 1, 0, 0, 0},
         '{2, R, R, 0, 0, 0, 0}, '{8, R, G, 0, 0, 0, 0}, '{3, R, Y, 0, 0, 0, 0},
         '{2, R, R, 0, 0, 0, 0}};
      for (int i = 0; i < 10; i++)
         for (int k = 0; k < int'(t[i].n); k++) begin
            checks++;
            if ({NS, EW, walk, ped_pending} !== {t[i].ns, t[i].ew, t[i].w, t[i].p})
               $display("FAIL ped row %0d cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                        i, k, NS, EW, walk, ped_pending, t[i].ns, t[i].ew, t[i].w, t[i].p);
            else passes++;
            ped_req = t[i].preq;
            flash_mode = t[i].fl;
            @(negedge clk);
         end
   endtask
   task automatic test_req_during_walk;
      vec_t t [12] = '{
         '{1, G, R, 0, 0, 1, 0}, '{7, G, R, 0, 1, 0, 0}, '{3, Y, R, 0, 1, 0, 0},
         '{2, R, R, 0, 1, 0, 0}, '{6, R, R, 1, 0, 1, 0}, '{2, R, R, 0, 0, 0, 0},
         '{8, R, G, 0, 0, 0, 0}, '{3, R, Y, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0},
         '{8, G, R, 0, 0, 0, 0}, '{3, Y, R, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0}};
      for (int i = 0; i < 12; i++)
         for (int k = 0; k < int'(t[i].n); k++) begin
            checks++;
            if ({NS, EW, walk, ped_pending} !== {t[i].ns, t[i].ew, t[i].w, t[i].p})
               $display("FAIL walk_req row %0d cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                        i, k, NS, EW, walk, ped_pending, t[i].ns, t[i].ew, t[i].w, t[i].p);
            else passes++;
            ped_req = t[i].preq;
            flash_mode = t[i].fl;
            @(negedge clk);
         end
   endtask
   task automatic test_flash;
      vec_t t [16] = '{
         '{8, R, G, 0, 0, 0, 0}, '{3, R, Y, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0},
         '{2, G, R, 0, 0, 0, 0}, '{6, G, R, 0, 0, 0, 0}, '{3, Y, R, 0, 0, 0, 0},
         '{2, R, R, 0, 0, 0, 0}, '{2, R, G, 0, 0, 0, 0}, '{6, R, G, 0, 0, 0, 1},
         '{3, R, Y, 0, 0, 0, 1}, '{2, R, R, 0, 0, 0, 1}, '{4, Y, Y, 0, 0, 0, 1},
         '{4, O, O, 0, 0, 0, 1}, '{2, Y, Y, 0, 0, 0, 1}, '{2, Y, Y, 0, 0, 0, 0},
         '{4, O, O, 0, 0, 0, 0}};
      vec_t u [7] = '{
         '{2, R, R, 0, 0, 0, 0}, '{8, G, R, 0, 0, 0, 0}, '{3, Y, R, 0, 0, 0, 0},
         '{2, R, R, 0, 0, 0, 0}, '{8, R, G, 0, 0, 0, 0}, '{3, R, Y, 0, 0, 0, 0},
         '{2, R, R, 0, 0, 0, 0}};
      // Realign to an EW_GREEN so flash can be raised there; first three rows finish a cycle.
      for (int i = 0; i < 16; i++)
         for (int k = 0; k < int'(t[i].n); k++) begin
            checks++;
            if ({NS, EW, walk, ped_pending} !== {t[i].ns, t[i].ew, t[i].w, t[i].p})
               $display("FAIL flash row %0d cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                        i, k, NS, EW, walk, ped_pending, t[i].ns, t[i].ew, t[i].w, t[i].p);
            else passes++;
            ped_req = t[i].preq;
            flash_mode = t[i].fl;
            @(negedge clk);
         end
      for (int i = 0; i < 7; i++)
         for (int k = 0; k < int'(u[i].n); k++) begin
            checks++;
            if ({NS, EW, walk, ped_pending} !== {u[i].ns, u[i].ew, u[i].w, u[i].p})
               $display("FAIL flash_exit row %0d cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                        i, k, NS, EW, walk, ped_pending, u[i].ns, u[i].ew, u[i].w, u[i].p);
            else passes++;
            ped_req = u[i].preq;
            flash_mode = u[i].fl;
            @(negedge clk);
         end
   endtask
   task automatic test_ped_through_flash;
      vec_t t [15] = '{
         '{8, G, R, 0, 0, 0, 1}, '{3, Y, R, 0, 0, 0, 1}, '{2, R, R, 0, 0, 0, 1},
         '{1, Y, Y, 0, 0, 1, 1}, '{3, Y, Y, 0, 1, 0, 1}, '{4, O, O, 0, 1, 0, 0},
         '{2, R, R, 0, 1, 0, 0}, '{6, R, R, 1, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0},
         '{8, G, R, 0, 0, 0, 0}, '{3, Y, R, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0},
         '{8, R, G, 0, 0, 0, 0}, '{3, R, Y, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0}};
      for (int i = 0; i < 15; i++)
         for (int k = 0; k < int'(t[i].n); k++) begin
            checks++;
            if ({NS, EW, walk, ped_pending} !== {t[i].ns, t[i].ew, t[i].w, t[i].p})
               $display("FAIL ped_flash row %0d cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                        i, k, NS, EW, walk, ped_pending, t[i].ns, t[i].ew, t[i].w, t[i].p);
            else passes++;
            ped_req = t[i].preq;
            flash_mode = t[i].fl;
            @(negedge clk);
         end
   endtask
   task automatic test_reset_mid;
      vec_t t [5] = '{
         '{1, G, R, 0, 0, 1, 0}, '{7, G, R, 0, 1, 0, 0}, '{3, Y, R, 0, 1, 0, 0},
         '{2, R, R, 0, 1, 0, 0}, '{3, R, R, 1, 0, 0, 0}};
      vec_t u [7] = '{
         '{8, G, R, 0, 0, 0, 0}, '{3, Y, R, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0},
         '{8, R, G, 0, 0, 0, 0}, '{3, R, Y, 0, 0, 0, 0}, '{2, R, R, 0, 0, 0, 0},
         '{1, G, R, 0, 0, 0, 0}};
      for (int i = 0; i < 5; i++)
         for (int k = 0; k < int'(t[i].n); k++) begin
            checks++;
            if ({NS, EW, walk, ped_pending} !== {t[i].ns, t[i].ew, t[i].w, t[i].p})
               $display("FAIL pre_reset row %0d cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                        i, k, NS, EW, walk, ped_pending, t[i].ns, t[i].ew, t[i].w, t[i].p);
            else passes++;
            ped_req = t[i].preq;
            flash_mode = t[i].fl;
            if (!(i == 4 && k == 2)) @(negedge clk);
         end
      // Still in PED_WALK cycle 3: one reset cycle, then the default sequence from scratch.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 7; i++)
         for (int k = 0; k < int'(u[i].n); k++) begin
            checks++;
            if ({NS, EW, walk, ped_pending} !== {u[i].ns, u[i].ew, u[i].w, u[i].p})
               $display("FAIL post_reset row %0d cyc %0d: got %b/%b/%b/%b expected %b/%b/%b/%b",
                        i, k, NS, EW, walk, ped_pending, u[i].ns, u[i].ew, u[i].w, u[i].p);
            else passes++;
            ped_req = u[i].preq;
            flash_mode = u[i].fl;
            @(negedge clk);
         end
   endtask
   initial begin
      test_reset;
      test_default_sequence;
      test_ped_request;
      test_req_during_walk;
      test_flash;
      test_ped_through_flash;
      test_reset_mid;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
